// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
//   arb_state_t : sequencer states (IDLE -> ACCESS -> DONE)
//   REQ_FETCH   : requester index of instruction fetch
//   REQ_DATA    : requester index of data load/store
//   LAT_W       : width of the access latency counter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   req0/1, addr0/1, wdata0/1, we0/1 : requests from fetch (0) and data (1)
//   ack0/1, rdata0/1                 : completion pulse and read data back
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : shared memory port
//   sel, busy                        : current owner and sequencer activity
// Modport slave is the arbiter; modport master is its environment.
interface mem_port_arbiter_if #(
   parameter int N = 32
);
   logic         req0, req1;
   logic [N-1:0] addr0, addr1;
   logic [N-1:0] wdata0, wdata1;
   logic         we0, we1;
   logic         ack0, ack1;
   logic [N-1:0] rdata0, rdata1;
   logic         mem_en, mem_we;
   logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         sel, busy;

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
      output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
             sel, busy
   );

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
      input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
             sel, busy
   );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
//   req0, req1  : pending requests
//   last_grant  : requester served most recently
//   grant_valid : at least one request pending
//   winner      : requester to serve next
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic winner
);
   assign grant_valid = req0 | req1;
   // On a tie the requester that was not served last wins; otherwise the
   // sole requester wins (req1 alone -> 1, req0 alone -> 0).
   assign winner = (req0 && req1) ? ~last_grant : req1;
endmodule

// File: rtl/mux2.sv
// Generic 2:1 multiplexer used for datapath steering.
//   sel : 0 selects a, 1 selects b
//   a, b: data inputs (W bits)
//   y   : selected data
module mux2 #(
   parameter int W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction
// fetch (requester 0) and data load/store (requester 1).
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : requester and memory port signals (slave side)
// A granted access holds the port for LAT cycles (ACCESS), then pulses the
// owner's ack for one cycle (DONE) before returning to IDLE.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N   = 32,
   parameter int LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   generate
      if (LAT < 1 || LAT > 15) begin : g_bad_lat
         $error("mem_port_arbiter: LAT must be in 1..15");
      end
   endgenerate

   arb_state_t       state_reg, state_next;
   logic             sel_reg, sel_next;
   logic             last_grant_reg, last_grant_next;
   logic [LAT_W-1:0] cnt_reg, cnt_next;
   logic [N-1:0]     rdata0_reg, rdata0_next;
   logic [N-1:0]     rdata1_reg, rdata1_next;

   logic grant_valid, winner;
   logic we_sel;

   rr_pick2 u_pick (
      .req0        (bus.req0),
      .req1        (bus.req1),
      .last_grant  (last_grant_reg),
      .grant_valid (grant_valid),
      .winner      (winner)
   );

   mux2 #(.W(N)) u_mux_addr (
      .sel (sel_reg), .a (bus.addr0), .b (bus.addr1), .y (bus.mem_addr)
   );

   mux2 #(.W(N)) u_mux_wdata (
      .sel (sel_reg), .a (bus.wdata0), .b (bus.wdata1), .y (bus.mem_wdata)
   );

   mux2 #(.W(1)) u_mux_we (
      .sel (sel_reg), .a (bus.we0), .b (bus.we1), .y (we_sel)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         sel_reg        <= REQ_FETCH;
         last_grant_reg <= REQ_DATA;   // fetch wins the first tie
         cnt_reg        <= '0;
         rdata0_reg     <= '0;
         rdata1_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         sel_reg        <= sel_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         rdata0_reg     <= rdata0_next;
         rdata1_reg     <= rdata1_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      rdata0_next     = rdata0_reg;
      rdata1_next     = rdata1_reg;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               sel_next   = winner;
               cnt_next   = LAT_W'(LAT - 1);
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_reg == '0) begin
               // Last access cycle: memory read data is valid now.
               if (!we_sel) begin
                  if (sel_reg == REQ_DATA) rdata1_next = bus.mem_rdata;
                  else                     rdata0_next = bus.mem_rdata;
               end
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - LAT_W'(1);
            end
         end
         DONE: begin
            last_grant_next = sel_reg;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy   = (state_reg != IDLE);
   assign bus.mem_en = (state_reg == ACCESS);
   assign bus.mem_we = (state_reg == ACCESS) && we_sel;
   assign bus.ack0   = (state_reg == DONE) && (sel_reg == REQ_FETCH);
   assign bus.ack1   = (state_reg == DONE) && (sel_reg == REQ_DATA);
   assign bus.sel    = sel_reg;
   assign bus.rdata0 = rdata0_reg;
   assign bus.rdata1 = rdata1_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer for a single shared memory port.
- Requester 0 is instruction fetch; requester 1 is data load/store.
- Drives the select of the existing 2:1 datapath multiplexers (mux2) that steer address, write data and write enable onto the shared port.
- Counts a fixed memory latency, returns read data, and pulses a per-requester ack.

Parameters:
- N, 32, data and address width in bits.
- LAT, 2, memory access latency in cycles; legal range 1..15; LAT=0 is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0 / req1  in  1  access request from requester 0 / 1.
- addr0 / addr1  in  N  request address.
- wdata0 / wdata1  in  N  write data.
- we0 / we1  in  1  1 = write, 0 = read.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  N  read data returned to the requester.
- mem_en  out  1  shared port access strobe.
- mem_we  out  1  shared port write enable.
- mem_addr  out  N  shared port address.
- mem_wdata  out  N  shared port write data.
- mem_rdata  in  N  shared port read data, valid in the last ACCESS cycle.
- sel  out  1  current owner; select for the mux2 instances.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, sel=0, last_grant=1 so requester 0 wins the first tie.
  - ack0=ack1=0, mem_en=0, mem_we=0, rdata0=rdata1=0, counter=0.
- States: IDLE, ACCESS, DONE (3-state FSM).
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_grant (strict alternation).
  - On a grant: sel<=winner, counter<=LAT-1, next state ACCESS.
- ACCESS:
  - mem_en=1; mem_we = the selected requester's we.
  - mem_addr and mem_wdata come from the mux2 instances using sel.
  - counter decrements each cycle. When counter=0: capture mem_rdata into rdata<sel> (reads only; writes leave rdata unchanged), then go to DONE.
- DONE:
  - ack<sel>=1 for exactly one cycle; mem_en=0.
  - last_grant<=sel; next state IDLE.
- Timing: request sampled in IDLE at cycle 0 -> ACCESS in cycles 1..LAT -> ack in cycle LAT+1 -> IDLE in cycle LAT+2.
- Throughput: one access per LAT+2 cycles.
- Outside ACCESS: mem_en=0, mem_we=0; mem_addr/mem_wdata are don't-care but driven by the mux.
- sel is stable from grant through DONE. It is never changed during ACCESS.
- Requester rules:
  - Hold req, addr, wdata and we stable until its ack.
  - Inputs sampled during ACCESS are the ones used; mid-access changes are a protocol violation and are not checked.
- req dropped mid-access: the access still completes and ack still pulses.
- req held high after ack: treated as a new request in the next IDLE cycle, subject to round-robin.
- rdataX holds its value until that requester's next completed read.
- Reset mid-operation:
  - Abort immediately at that edge; no ack is issued.
  - mem_en is low from the next cycle.
  - last_grant returns to 1.
- ack0 and ack1 are never high together. Only the winner's ack pulses.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t.
  - constants REQ_FETCH=0 and REQ_DATA=1.
  - LAT_W=4 (counter width).
- Steering reuses the existing mux2 module: N-bit for addr and wdata, 1-bit for we. No new mux logic.
- One natural sub-module: rr_pick2. It is combinational: inputs req0, req1, last_grant; outputs grant_valid and winner.

Test Plan (LAT=2):
- Reset hold: rst_n=0 for 3 cycles with req0=req1=1 -> ack0=ack1=0, mem_en=0, sel=0, busy=0 throughout.
- Single read: req0=1, addr0=0x00000040, mem_rdata=0xDEADBEEF -> mem_en high in cycles 1-2 with mem_addr=0x40, ack0 in cycle 3, rdata0=0xDEADBEEF, IDLE in cycle 4.
- Single write: req1=1, we1=1, addr1=0x100, wdata1=0x12345678 -> mem_we=1, mem_wdata=0x12345678 in cycles 1-2, ack1 in cycle 3, rdata1 unchanged.
- Contention: req0=req1=1 held continuously from reset -> grants alternate 0,1,0,1; acks at cycles 3, 7, 11, 15; sel toggles accordingly.
- Back-to-back single requester: req0 held for 3 accesses -> ack0 at cycles 3, 7, 11; sel stays 0.
- Reset mid-access: rst_n=0 during the second ACCESS cycle of a req1 read -> no ack1, mem_en=0 next cycle, the following tie is granted to requester 0.
